// File: rtl/stream_pkg.sv
// Shared defaults for the stream width converters (stream_upsize, stream_downsize).
package stream_pkg;

    localparam int unsigned T_DATA_WIDTH_DEF = 8;
    localparam int unsigned T_DATA_RATIO_DEF = 4;

    // Lane counter width for a given ratio; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(T_DATA_RATIO_DEF);

    // Lane counter type at the default ratio.
    typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/stream_reg_slice.sv
// Output register for the upsizer: holds one wide beat plus its valid/ready handshake.
// Optional macro STREAM_UPSIZE_KEEP_EN adds the per-lane keep mask.
module stream_reg_slice
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = T_DATA_WIDTH_DEF,
    parameter int unsigned T_DATA_RATIO = T_DATA_RATIO_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [T_DATA_WIDTH-1:0] i_data [T_DATA_RATIO-1:0],
`ifdef STREAM_UPSIZE_KEEP_EN
    input  logic [T_DATA_RATIO-1:0] i_keep,
    output logic [T_DATA_RATIO-1:0] o_keep,
`endif
    input  logic                    i_last,
    input  logic                    i_ready,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [T_DATA_WIDTH-1:0] o_data [T_DATA_RATIO-1:0],
    output logic                    o_last
);

    logic                    r_valid;
    logic                    r_last;
    logic [T_DATA_WIDTH-1:0] r_data [T_DATA_RATIO-1:0];
`ifdef STREAM_UPSIZE_KEEP_EN
    logic [T_DATA_RATIO-1:0] r_keep;
`endif

    // Beat register: a load replaces the current beat; otherwise a handshake empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            for (int i = 0; i < int'(T_DATA_RATIO); i++) begin
                r_data[i] <= '0;
            end
`ifdef STREAM_UPSIZE_KEEP_EN
            r_keep  <= '0;
`endif
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_last  <= i_last;
            r_data  <= i_data;
`ifdef STREAM_UPSIZE_KEEP_EN
            r_keep  <= i_keep;
`endif
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Ready only looks at the register state and downstream ready, never at the input word.
    always_comb begin
        o_ready = !r_valid || i_ready;
        o_valid = r_valid;
        o_last  = r_last;
        o_data  = r_data;
`ifdef STREAM_UPSIZE_KEEP_EN
        o_keep  = r_keep;
`endif
    end

endmodule

// File: rtl/stream_upsize.sv
// Narrow-to-wide stream packer: gathers T_DATA_RATIO words (or fewer at packet end) into one beat.
// Optional macro STREAM_UPSIZE_KEEP_EN adds the m_keep_o lane mask.
module stream_upsize
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = T_DATA_WIDTH_DEF,
    parameter int unsigned T_DATA_RATIO = T_DATA_RATIO_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
`ifdef STREAM_UPSIZE_KEEP_EN
    output logic [T_DATA_RATIO-1:0] m_keep_o,
`endif
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int unsigned CNT_W = cnt_width(T_DATA_RATIO);

    logic [CNT_W-1:0]        r_cnt;
    logic [T_DATA_WIDTH-1:0] r_acc [T_DATA_RATIO-2:0];

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_complete;
    logic [T_DATA_WIDTH-1:0] w_beat [T_DATA_RATIO-1:0];
`ifdef STREAM_UPSIZE_KEEP_EN
    logic [T_DATA_RATIO-1:0] w_keep;
`endif

    // Handshake decode and assembly of the beat that a completing word would produce.
    always_comb begin
        w_accept   = s_valid_i && w_ready;
        w_complete = w_accept && ((r_cnt == CNT_W'(T_DATA_RATIO - 1)) || s_last_i);
        for (int i = 0; i < int'(T_DATA_RATIO); i++) begin
            w_beat[i] = '0;
        end
        for (int i = 0; i < int'(T_DATA_RATIO) - 1; i++) begin
            if (i < int'(r_cnt)) begin
                w_beat[i] = r_acc[i];
            end
        end
        for (int i = 0; i < int'(T_DATA_RATIO); i++) begin
            if (i == int'(r_cnt)) begin
                w_beat[i] = s_data_i;
            end
        end
`ifdef STREAM_UPSIZE_KEEP_EN
        for (int i = 0; i < int'(T_DATA_RATIO); i++) begin
            w_keep[i] = (i <= int'(r_cnt));
        end
`endif
    end

    // Counter and accumulator: park non-completing words, restart the count on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            for (int i = 0; i < int'(T_DATA_RATIO) - 1; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_complete) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc[r_cnt] <= s_data_i;
            r_cnt        <= r_cnt + CNT_W'(1);
        end
    end

    stream_reg_slice #(
        .T_DATA_WIDTH (T_DATA_WIDTH),
        .T_DATA_RATIO (T_DATA_RATIO)
    ) u_reg_slice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_complete),
        .i_data  (w_beat),
`ifdef STREAM_UPSIZE_KEEP_EN
        .i_keep  (w_keep),
        .o_keep  (m_keep_o),
`endif
        .i_last  (s_last_i),
        .i_ready (m_ready_i),
        .o_ready (w_ready),
        .o_valid (m_valid_o),
        .o_data  (m_data_o),
        .o_last  (m_last_o)
    );

    assign s_ready_o = w_ready;

endmodule

// File: tb/tb_stream_upsize.sv
// Scoreboard bench for stream_upsize (WIDTH=8, RATIO=4); keep checks follow STREAM_UPSIZE_KEEP_EN.
module tb_stream_upsize;

    localparam int W = 8;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] s_data_i;
    logic         s_last_i;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [W-1:0] m_data_o [R-1:0];
    logic         m_last_o;
    logic         m_valid_o;
    logic         m_ready_i;
`ifdef STREAM_UPSIZE_KEEP_EN
    logic [R-1:0] m_keep_o;
`endif

    stream_upsize #(
        .T_DATA_WIDTH (W),
        .T_DATA_RATIO (R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data_i),
        .s_last_i  (s_last_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
`ifdef STREAM_UPSIZE_KEEP_EN
        .m_keep_o  (m_keep_o),
`endif
        .m_last_o  (m_last_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i)
    );

    always #5 clk = ~clk;

    logic [31:0] w_flat;
    always_comb begin
        w_flat = '0;
        for (int i = 0; i < R; i++) begin
            w_flat[i*8 +: 8] = m_data_o[i];
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    beat_t        exp_q [$];
    logic [W-1:0] macc [$];
    int           n_cmp;
    int           n_fail;
    int           rmode;
    bit           gaps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference packer: collects accepted words, emits an expected beat on full or last.
    task automatic model_accept(input logic [W-1:0] d, input logic l);
        beat_t b;
        macc.push_back(d);
        if (macc.size() == R || l) begin
            b.data = '0;
            b.keep = '0;
            for (int i = 0; i < macc.size(); i++) begin
                b.data[i*8 +: 8] = macc[i];
                b.keep[i]        = 1'b1;
            end
            b.last = l;
            exp_q.push_back(b);
            macc.delete();
        end
    endtask

    // Samples at negedge: what is seen here is what the next rising edge will act on.
    task automatic monitor();
        logic [31:0] prev_data;
        logic        prev_last;
        bit          stall;
        beat_t       b;
        stall     = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                macc.delete();
                exp_q.delete();
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_data", w_flat, prev_data);
                    check("hold_last", m_last_o, prev_last);
                end
                if (m_valid_o && m_ready_i) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check("beat_data", w_flat, b.data);
                        check("beat_last", m_last_o, b.last);
`ifdef STREAM_UPSIZE_KEEP_EN
                        check("beat_keep", m_keep_o, b.keep);
`endif
                    end
                end
                stall     = m_valid_o && !m_ready_i;
                prev_data = w_flat;
                prev_last = m_last_o;
                if (s_valid_i && s_ready_o) begin
                    model_accept(s_data_i, s_last_i);
                end
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            if (rmode == 0)      m_ready_i = 1'b0;
            else if (rmode == 1) m_ready_i = 1'b1;
            else                 m_ready_i = ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        if (gaps) begin
            while ($urandom_range(0, 9) < 2) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (s_ready_o) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        check("accept_timeout", ok, 1);
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0 && !m_valid_o) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wt;
        int len;
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;
        rmode     = 1;
        gaps      = 1'b0;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", m_valid_o, 0);
        check("rst_ready", s_ready_o, 1);
        check("rst_data", w_flat, 0);
        check("rst_last", m_last_o, 0);
`ifdef STREAM_UPSIZE_KEEP_EN
        check("rst_keep", m_keep_o, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full beat, first word taken on the first edge after reset release
        send(8'h11, 1'b0, wt);
        check("first_accept_wait", wt, 0);
        send(8'h22, 1'b0, wt);
        send(8'h33, 1'b0, wt);
        send(8'h44, 1'b1, wt);
        @(negedge clk);
        check("full_valid", m_valid_o, 1);
        check("full_data", w_flat, 32'h4433_2211);
        check("full_last", m_last_o, 1);
`ifdef STREAM_UPSIZE_KEEP_EN
        check("full_keep", m_keep_o, 4'b1111);
`endif
        @(posedge clk);
        #1;

        // Partial beat, then a full non-last beat proves the counter restarted
        send(8'hA1, 1'b0, wt);
        send(8'hA2, 1'b1, wt);
        @(negedge clk);
        check("part_data", w_flat, 32'h0000_A2A1);
        check("part_last", m_last_o, 1);
`ifdef STREAM_UPSIZE_KEEP_EN
        check("part_keep", m_keep_o, 4'b0011);
`endif
        @(posedge clk);
        #1;
        send(8'hB1, 1'b0, wt);
        send(8'hB2, 1'b0, wt);
        send(8'hB3, 1'b0, wt);
        send(8'hB4, 1'b0, wt);
        @(negedge clk);
        check("after_part_data", w_flat, 32'hB4B3_B2B1);
        check("after_part_last", m_last_o, 0);
        @(posedge clk);
        #1;

        // Single-word packet
        send(8'h5A, 1'b1, wt);
        @(negedge clk);
        check("single_data", w_flat, 32'h0000_005A);
        check("single_last", m_last_o, 1);
`ifdef STREAM_UPSIZE_KEEP_EN
        check("single_keep", m_keep_o, 4'b0001);
`endif
        @(posedge clk);
        #1;

        // Backpressure: first beat must hold while words keep being offered
        rmode = 0;
        repeat (2) @(posedge clk);
        #1;
        send(8'h01, 1'b0, wt);
        send(8'h02, 1'b0, wt);
        send(8'h03, 1'b0, wt);
        send(8'h04, 1'b0, wt);
        s_valid_i = 1'b1;
        s_data_i  = 8'h05;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready_low", s_ready_o, 0);
            check("bp_valid", m_valid_o, 1);
            check("bp_data", w_flat, 32'h0403_0201);
        end
        rmode = 1;
        send(8'h05, 1'b0, wt);
        send(8'h06, 1'b0, wt);
        send(8'h07, 1'b0, wt);
        send(8'h08, 1'b1, wt);
        drain();

        // Reset mid-packet: the two parked words must never surface
        send(8'hC1, 1'b0, wt);
        send(8'hC2, 1'b0, wt);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", m_valid_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'hD1, 1'b0, wt);
        send(8'hD2, 1'b0, wt);
        send(8'hD3, 1'b0, wt);
        send(8'hD4, 1'b0, wt);
        @(negedge clk);
        check("postrst_data", w_flat, 32'hD4D3_D2D1);
        @(posedge clk);
        #1;
        drain();

        // Random traffic: ~80% valid, ~10% ready
        gaps  = 1'b1;
        rmode = 2;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                send(8'($urandom), (j == len - 1), wt);
            end
        end
        gaps  = 1'b0;
        rmode = 1;
        drain();
        check("model_residue", macc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_upsize.md
STREAM_UPSIZE -- requirements
Module: stream_upsize

Interface
REQ-001 SHALL have parameter T_DATA_WIDTH, default 8, width of one narrow input word in bits.
REQ-002 SHALL have parameter T_DATA_RATIO, default 4, number of narrow words per wide output beat; legal values >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_data_i  input  T_DATA_WIDTH  narrow input word.
REQ-006 SHALL have port s_last_i  input  1  marks final word of a packet.
REQ-007 SHALL have port s_valid_i  input  1  input word valid.
REQ-008 SHALL have port s_ready_o  output  1  input word accepted when high with s_valid_i.
REQ-009 SHALL have port m_data_o  output  T_DATA_WIDTH x [T_DATA_RATIO-1:0] unpacked  wide beat; index 0 holds the first word received.
REQ-010 SHALL have port m_keep_o  output  T_DATA_RATIO  per-lane valid mask (present only per REQ-027).
REQ-011 SHALL have port m_last_o  output  1  beat ends a packet.
REQ-012 SHALL have port m_valid_o  output  1  output beat valid.
REQ-013 SHALL have port m_ready_i  input  1  downstream accepts beat.

Function
REQ-014 SHALL accept a word on a cycle with s_valid_i && s_ready_o, and only on such a cycle.
REQ-015 SHALL keep a word counter cnt (0..T_DATA_RATIO-1, width $clog2(T_DATA_RATIO)) and a (T_DATA_RATIO-1)-word accumulator; a non-completing accepted word is written to lane cnt, and cnt increments.
REQ-016 SHALL treat an accepted word as completing when cnt == T_DATA_RATIO-1 or s_last_i == 1.
REQ-017 SHALL, on a completing word, load the output register with accumulator lanes 0..cnt-1 plus the current word in lane cnt, set m_valid_o on the next cycle, set m_last_o = s_last_i, and reset cnt to 0.
REQ-018 SHALL drive unused lanes (index > cnt of completing word) of m_data_o to zero.
REQ-019 SHALL drive s_ready_o = !m_valid_o || m_ready_i, with no combinational dependence on s_valid_i or s_last_i.
REQ-020 SHALL hold m_data_o, m_keep_o and m_last_o stable while m_valid_o && !m_ready_i.
REQ-021 SHALL clear m_valid_o after a handshake unless a completing word is accepted in the same cycle, in which case the new beat replaces the old one back-to-back.
REQ-022 SHALL sustain one word per cycle when m_ready_i is held high: a full beat every T_DATA_RATIO cycles.
REQ-023 SHALL have a latency of one cycle from acceptance of the completing word to m_valid_o.

Reset
REQ-024 SHALL, while rst is high, force m_valid_o=0, m_last_o=0, m_data_o lanes=0, m_keep_o=0, cnt=0 and accumulator=0; s_ready_o is then 1.
REQ-025 SHALL discard any partially accumulated packet and any pending output beat when rst is asserted mid-operation, with no beat emitted for them after release.
REQ-026 SHALL accept a word on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with macro STREAM_UPSIZE_KEEP_EN defined, provide m_keep_o with bits 0..cnt set for the completing word, so a full beat is all ones; without the macro, m_keep_o SHALL be absent, partial beats SHALL be zero-padded, and all other behaviour SHALL be identical.

Structure
REQ-028 SHALL take default width/ratio constants and the counter typedef from shared package stream_pkg, which is also used by stream_downsize.
REQ-029 SHALL implement the output register and its valid/ready logic as sub-module stream_reg_slice; the accumulator and counter SHALL remain in the top.

Verification
REQ-030 SHALL cover a full beat: WIDTH=8, RATIO=4, m_ready_i=1, words 0x11,0x22,0x33,0x44 with last on 0x44 -> one cycle later m_data_o={0x44,0x33,0x22,0x11} (lane0=0x11), m_keep_o=4'b1111, m_last_o=1.
REQ-031 SHALL cover a partial beat: words 0xA1,0xA2 with last on 0xA2 -> m_data_o lanes {0,0,0xA2,0xA1}, m_keep_o=4'b0011, m_last_o=1, cnt returns to 0.
REQ-032 SHALL cover backpressure: m_ready_i=0 while 8 words are offered -> first beat holds stable, s_ready_o=0 after the 4th word, no word lost; after m_ready_i=1 both beats emerge in order.
REQ-033 SHALL cover a single-word packet: one word 0x5A with last -> m_keep_o=4'b0001, m_last_o=1.
REQ-034 SHALL cover reset mid-packet: 2 words accepted, rst pulsed -> no beat emitted; the next 4 words form a full beat with lane0 = first post-reset word.
REQ-035 SHALL cover random throughput: 200 random packets with 80% valid and 10% ready -> the scoreboard matches the concatenated output against the input stream and the last flags against the packet boundaries.
